cpu_bus_ctrl: RTL and testbench
===============================

// Module: cpu_bus_ctrl
// PURPOSE
// Bus-cycle sequencer between the fx68k-based CPU wrapper and the main memory/IO port.
// Detects each 68000 bus cycle, turns it into a single read/write request on a ready/valid
// memory port, returns read data and drives DTACK. Handles interrupt-acknowledge cycles
// by autovectoring (VPA), and enforces a timeout so a dead slave cannot hang the CPU.
// PARAMETERS
// ADDR_WIDTH  23    word-address width (CPU A23..A1)
// DATA_WIDTH  16    data bus width
// TIMEOUT     255   max cycles in REQ+WAIT_DATA before forced termination (>=2)
// PORTS
// clock        in   1   system clock (CPU enPhi1/enPhi2 derived from same clock)
// reset        in   1   synchronous, active-high
// cpu_as       in   1   address strobe (active-high)
// cpu_rw       in   1   1=read, 0=write
// cpu_uds      in   1   upper data strobe (active-high)
// cpu_lds      in   1   lower data strobe (active-high)
// cpu_fc       in   3   function code
// cpu_addr     in   ADDR_WIDTH  word address
// cpu_dout     in   DATA_WIDTH  CPU write data
// cpu_din      out  DATA_WIDTH  read data to CPU (registered)
// cpu_dtack    out  1   data acknowledge (active-high)
// cpu_vpa      out  1   valid peripheral address, used for autovector IACK
// mem_rd       out  1   read request (level, held until accepted)
// mem_wr       out  1   write request (level, held until accepted)
// mem_addr     out  ADDR_WIDTH  latched request address
// mem_mask     out  2   byte mask {uds,lds}
// mem_dout     out  DATA_WIDTH  latched write data
// mem_ready    in   1   request accepted this cycle when mem_rd|mem_wr
// mem_valid    in   1   read data valid on mem_din
// mem_din      in   DATA_WIDTH  read data
// timeout      out  1   one-cycle pulse when a cycle is force-terminated
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (cpu_din=0, mask/addr/dout=0); counter cleared.
// - Cycle start = cpu_as rising edge (as && !as_q) with (uds|lds); as_q is a 1-cycle delay.
// - IDLE: on start, fc==3'b111 -> IACK; else latch addr, {uds,lds}, dout, rw -> REQ.
//   mem_valid in IDLE is ignored (late data from abandoned/timed-out reads).
// - REQ: mem_rd=rw, mem_wr=!rw; addr/mask/dout stable. On mem_ready: write -> ACK;
//   read -> ACK if mem_valid same cycle (cpu_din<=mem_din), else WAIT_DATA.
//   cpu_as falls before acceptance -> drop request, IDLE, no DTACK.
// - WAIT_DATA: requests low. On mem_valid: cpu_din<=mem_din -> ACK. cpu_as falling here
//   does not abort: wait for mem_valid, then IDLE without DTACK.
// - ACK: cpu_dtack=1 from the cycle after entry until cpu_as seen low, then IDLE
//   (dtack drops the cycle after as falls). Back-to-back cycles need a new as edge.
// - IACK: cpu_vpa=1 until cpu_as low, then IDLE; no memory request issued.
// - Timeout: counter resets on entry to REQ, increments each cycle in REQ/WAIT_DATA; on
//   reaching TIMEOUT: drop requests, cpu_din<=all ones, pulse timeout, -> ACK.
// - Reset mid-cycle returns to IDLE in one cycle; any outstanding request is abandoned.
// TESTING
// - Read 0x012345, mem_ready at +2, mem_valid at +4 data 0xBEEF -> mem_rd high 3 cycles, cpu_din=0xBEEF, dtack until as low.
// - Byte write lds only, dout 0x00AA, mem_ready immediate -> one mem_wr cycle, mask=2'b01, dtack next cycle.
// - IACK (fc=7, as high) -> vpa=1, mem_rd/mem_wr never asserted, vpa drops after as low.
// - Read, mem_ready never -> timeout pulse at TIMEOUT cycles, cpu_din=0xFFFF, dtack asserted.
// - Read accepted, reset asserted before mem_valid -> all outputs 0 next cycle; later mem_valid ignored.
// - as drops in REQ before mem_ready -> requests drop, no dtack; next as edge starts fresh cycle.

Source files
------------

// File: rtl/cpu_bus_ctrl.sv
// Bus-cycle sequencer between the 68000 CPU wrapper and a ready/valid memory port.
// Each address-strobe edge becomes one memory request; IACK cycles are autovectored.
module cpu_bus_ctrl #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_as,
    input  logic                  cpu_rw,
    input  logic                  cpu_uds,
    input  logic                  cpu_lds,
    input  logic [2:0]            cpu_fc,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_dout,
    output logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  cpu_dtack,
    output logic                  cpu_vpa,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_mask,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic                  timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_ACK,
        S_IACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    as_q;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic                    timeout_q, timeout_d;
    logic                    start;
    logic                    expired;

    assign start   = cpu_as & ~as_q & (cpu_uds | cpu_lds);
    // Counter is checked before increment, so requests stay up for exactly TIMEOUT cycles.
    assign expired = (cnt_q >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            as_q      <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            as_q      <= cpu_as;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    if (cpu_fc == 3'b111) begin
                        state_d = S_IACK;
                    end else begin
                        rw_d    = cpu_rw;
                        addr_d  = cpu_addr;
                        mask_d  = {cpu_uds, cpu_lds};
                        wdata_d = cpu_dout;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    if (!rw_q) begin
                        state_d = S_ACK;
                    end else if (mem_valid) begin
                        din_d   = mem_din;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end else if (!cpu_as) begin
                    state_d = S_IDLE;
                end else if (expired) begin
                    din_d     = '1;
                    timeout_d = 1'b1;
                    state_d   = S_ACK;
                end
            end

            S_WAIT_DATA: begin
                cnt_d = cnt_q + 1'b1;
                // The accepted read must still drain even if the CPU gave up on it.
                if (!cpu_as) begin
                    abort_d = 1'b1;
                end
                if (mem_valid) begin
                    if (abort_q || !cpu_as) begin
                        state_d = S_IDLE;
                    end else begin
                        din_d   = mem_din;
                        state_d = S_ACK;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    if (abort_q || !cpu_as) begin
                        state_d = S_IDLE;
                    end else begin
                        din_d   = '1;
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (!cpu_as) begin
                    state_d = S_IDLE;
                end
            end

            S_IACK: begin
                if (!cpu_as) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_rd    = (state_q == S_REQ) &  rw_q;
    assign mem_wr    = (state_q == S_REQ) & ~rw_q;
    assign cpu_dtack = (state_q == S_ACK);
    assign cpu_vpa   = (state_q == S_IACK);
    assign mem_addr  = addr_q;
    assign mem_mask  = mask_q;
    assign mem_dout  = wdata_q;
    assign cpu_din   = din_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: inputs change and outputs are checked on the falling edge.
module tb_cpu_bus_ctrl;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int TO = 255;

    logic          clock;
    logic          reset;
    logic          cpu_as;
    logic          cpu_rw;
    logic          cpu_uds;
    logic          cpu_lds;
    logic [2:0]    cpu_fc;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic          cpu_dtack;
    logic          cpu_vpa;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_mask;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          mem_valid;
    logic [DW-1:0] mem_din;
    logic          timeout;

    int checks   = 0;
    int failures = 0;
    int rd_cnt;
    int n;

    cpu_bus_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_as   (cpu_as),
        .cpu_rw   (cpu_rw),
        .cpu_uds  (cpu_uds),
        .cpu_lds  (cpu_lds),
        .cpu_fc   (cpu_fc),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .cpu_dtack(cpu_dtack),
        .cpu_vpa  (cpu_vpa),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_mask (mem_mask),
        .mem_dout (mem_dout),
        .mem_ready(mem_ready),
        .mem_valid(mem_valid),
        .mem_din  (mem_din),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_start(input logic rw, input logic uds, input logic lds,
                             input logic [2:0] fc, input logic [AW-1:0] addr,
                             input logic [DW-1:0] dout);
        cpu_as   = 1'b1;
        cpu_rw   = rw;
        cpu_uds  = uds;
        cpu_lds  = lds;
        cpu_fc   = fc;
        cpu_addr = addr;
        cpu_dout = dout;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_as    = 1'b0;
        cpu_rw    = 1'b1;
        cpu_uds   = 1'b0;
        cpu_lds   = 1'b0;
        cpu_fc    = 3'b000;
        cpu_addr  = '0;
        cpu_dout  = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_din   = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_dtack", 32'(cpu_dtack), 32'd0);
        chk("rst_vpa",   32'(cpu_vpa),   32'd0);
        chk("rst_rd",    32'(mem_rd),    32'd0);
        chk("rst_wr",    32'(mem_wr),    32'd0);
        chk("rst_din",   32'(cpu_din),   32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_mask",  32'(mem_mask),  32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();
        $display("txn reset done");

        // Word read, ready on third request cycle, data two cycles later
        cpu_start(1'b1, 1'b1, 1'b1, 3'b101, 23'h012345, 16'h0000);
        tick();
        chk("rd1_rd_c1", 32'(mem_rd),   32'd1);
        chk("rd1_addr",  32'(mem_addr), 32'h012345);
        chk("rd1_mask",  32'(mem_mask), 32'd3);
        tick();
        chk("rd1_rd_c2", 32'(mem_rd), 32'd1);
        tick();
        chk("rd1_rd_c3", 32'(mem_rd), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rd1_rd_wait",    32'(mem_rd),    32'd0);
        chk("rd1_dtack_wait", 32'(cpu_dtack), 32'd0);
        tick();
        mem_valid = 1'b1;
        mem_din   = 16'hBEEF;
        tick();
        mem_valid = 1'b0;
        mem_din   = 16'h0000;
        chk("rd1_dtack", 32'(cpu_dtack), 32'd1);
        chk("rd1_din",   32'(cpu_din),   32'hBEEF);
        tick();
        chk("rd1_dtack_hold", 32'(cpu_dtack), 32'd1);
        cpu_as = 1'b0;
        tick();
        chk("rd1_dtack_drop", 32'(cpu_dtack), 32'd0);
        $display("txn read 012345 din=%h", cpu_din);

        // Byte write, low lane only, immediate accept
        cpu_start(1'b0, 1'b0, 1'b1, 3'b101, 23'h000100, 16'h00AA);
        mem_ready = 1'b1;
        tick();
        chk("wr_wr",   32'(mem_wr),   32'd1);
        chk("wr_rd",   32'(mem_rd),   32'd0);
        chk("wr_mask", 32'(mem_mask), 32'd1);
        chk("wr_dout", 32'(mem_dout), 32'h00AA);
        chk("wr_addr", 32'(mem_addr), 32'h000100);
        tick();
        mem_ready = 1'b0;
        chk("wr_wr_once", 32'(mem_wr),    32'd0);
        chk("wr_dtack",   32'(cpu_dtack), 32'd1);
        cpu_as = 1'b0;
        tick();
        chk("wr_dtack_drop", 32'(cpu_dtack), 32'd0);
        $display("txn write 000100 mask=01 data=00AA");

        // Interrupt acknowledge
        cpu_start(1'b1, 1'b1, 1'b1, 3'b111, 23'h7FFFF8, 16'h0000);
        tick();
        chk("iack_vpa",   32'(cpu_vpa),   32'd1);
        chk("iack_rd",    32'(mem_rd),    32'd0);
        chk("iack_wr",    32'(mem_wr),    32'd0);
        chk("iack_dtack", 32'(cpu_dtack), 32'd0);
        tick();
        chk("iack_vpa_hold", 32'(cpu_vpa), 32'd1);
        chk("iack_rd_hold",  32'(mem_rd),  32'd0);
        cpu_as = 1'b0;
        tick();
        chk("iack_vpa_drop", 32'(cpu_vpa), 32'd0);
        $display("txn iack autovector");

        // Read that is never accepted
        cpu_start(1'b1, 1'b1, 1'b1, 3'b101, 23'h7FFFFF, 16'h0000);
        rd_cnt = 0;
        n      = 0;
        tick();
        while (!timeout && n < 400) begin
            if (mem_rd) rd_cnt++;
            n++;
            tick();
        end
        chk("to_pulse",   32'(timeout),   32'd1);
        chk("to_rd_cyc",  32'(rd_cnt),    32'(TO));
        chk("to_din",     32'(cpu_din),   32'hFFFF);
        chk("to_dtack",   32'(cpu_dtack), 32'd1);
        chk("to_rd_drop", 32'(mem_rd),    32'd0);
        tick();
        chk("to_pulse_end", 32'(timeout),   32'd0);
        chk("to_dtack_hold", 32'(cpu_dtack), 32'd1);
        cpu_as = 1'b0;
        tick();
        chk("to_dtack_drop", 32'(cpu_dtack), 32'd0);
        $display("txn read 7FFFFF timeout after %0d request cycles", rd_cnt);

        // Reset while a read is outstanding; late data must be ignored
        cpu_start(1'b1, 1'b1, 1'b1, 3'b101, 23'h000200, 16'h0000);
        mem_ready = 1'b1;
        tick();
        chk("rr_rd", 32'(mem_rd), 32'd1);
        tick();
        mem_ready = 1'b0;
        chk("rr_wait_rd", 32'(mem_rd), 32'd0);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        cpu_as = 1'b0;
        chk("rr_din",   32'(cpu_din),   32'd0);
        chk("rr_addr",  32'(mem_addr),  32'd0);
        chk("rr_mask",  32'(mem_mask),  32'd0);
        chk("rr_dtack", 32'(cpu_dtack), 32'd0);
        chk("rr_rd_0",  32'(mem_rd),    32'd0);
        mem_valid = 1'b1;
        mem_din   = 16'h1234;
        tick();
        mem_valid = 1'b0;
        mem_din   = 16'h0000;
        tick();
        chk("rr_late_din",   32'(cpu_din),   32'd0);
        chk("rr_late_dtack", 32'(cpu_dtack), 32'd0);
        $display("txn reset mid-read, late data ignored");

        // Strobe withdrawn before acceptance, then a fresh write cycle
        cpu_start(1'b1, 1'b1, 1'b1, 3'b101, 23'h000300, 16'h0000);
        tick();
        chk("ab_rd", 32'(mem_rd), 32'd1);
        cpu_as = 1'b0;
        tick();
        chk("ab_rd_drop", 32'(mem_rd),    32'd0);
        chk("ab_dtack",   32'(cpu_dtack), 32'd0);
        tick();
        chk("ab_dtack_idle", 32'(cpu_dtack), 32'd0);
        cpu_start(1'b0, 1'b1, 1'b1, 3'b101, 23'h000304, 16'h5555);
        mem_ready = 1'b1;
        tick();
        chk("ab2_wr",   32'(mem_wr),   32'd1);
        chk("ab2_addr", 32'(mem_addr), 32'h000304);
        chk("ab2_dout", 32'(mem_dout), 32'h5555);
        tick();
        mem_ready = 1'b0;
        chk("ab2_dtack", 32'(cpu_dtack), 32'd1);
        cpu_as = 1'b0;
        tick();
        chk("ab2_dtack_drop", 32'(cpu_dtack), 32'd0);
        $display("txn abort then write 000304");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
